// File: rtl/imem_read_responder.sv
// Memory-side responder for the I-cache refill read handshake: a word-addressed
// instruction store answering held read requests with a mem_ready pulse after LATENCY cycles.
module imem_read_responder #(
    parameter int WORD_AW = 12,
    parameter int LATENCY = 4,
    parameter int CNT_W   = 32
) (
    input  logic               cpu_clk,
    input  logic               rst,
    input  logic               r_mem,
    input  logic [31:0]        mem_addr,
    output logic [31:0]        mem_r_data,
    output logic               mem_ready,
    input  logic               ld_we,
    input  logic [WORD_AW-1:0] ld_addr,
    input  logic [31:0]        ld_data,
    output logic               busy,
    output logic               proto_err,
    output logic [CNT_W-1:0]   refill_cnt,
    output logic [CNT_W-1:0]   abort_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        rdata_q;
    logic [CNT_W-1:0]   refill_q, refill_d;
    logic [CNT_W-1:0]   abort_q, abort_d;
    logic               perr_q, perr_d;
    logic               load_rdata;

    logic [31:0]        mem_q [2**WORD_AW];
    logic [WORD_AW-1:0] rd_idx;
    logic [31:0]        rd_word;

    // NOTE: the store is a plain RAM with no reset branch, so it can map onto block memory;
    // its contents survive rst and are only ever defined by the preload port.
    always_ff @(posedge cpu_clk) begin
        if (ld_we) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    // With LATENCY==1 the read happens straight from IDLE, so it must use the live address.
    always_comb begin
        rd_idx  = (state_q == ST_IDLE) ? mem_addr[WORD_AW+1:2] : addr_q[WORD_AW+1:2];
        rd_word = (ld_we && (ld_addr == rd_idx)) ? ld_data : mem_q[rd_idx];
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned,
        // which would otherwise infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        refill_d   = refill_q;
        abort_d    = abort_q;
        perr_d     = perr_q;
        load_rdata = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (r_mem) begin
                    addr_d = mem_addr;
                    cnt_d  = LAT_M1;
                    if (mem_addr[1:0] != 2'b00) begin
                        perr_d = 1'b1;
                    end
                    if (LATENCY > 1) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d    = ST_RESP;
                        load_rdata = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!r_mem) begin
                    state_d = ST_IDLE;
                    abort_d = abort_q + CNT_W'(1);
                end else begin
                    if (mem_addr != addr_q) begin
                        perr_d = 1'b1;
                    end
                    if (cnt_q == 8'd1) begin
                        state_d    = ST_RESP;
                        load_rdata = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            ST_RESP: begin
                state_d  = ST_IDLE;
                refill_d = refill_q + CNT_W'(1);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            addr_q   <= 32'd0;
            rdata_q  <= 32'd0;
            refill_q <= '0;
            abort_q  <= '0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            refill_q <= refill_d;
            abort_q  <= abort_d;
            perr_q   <= perr_d;
            if (load_rdata) begin
                rdata_q <= rd_word;
            end
        end
    end

    assign mem_r_data = rdata_q;
    assign mem_ready  = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);
    assign proto_err  = perr_q;
    assign refill_cnt = refill_q;
    assign abort_cnt  = abort_q;

endmodule

// File: tb/tb_imem_read_responder.sv
// Self-checking bench for imem_read_responder: the bench acts as the I-cache initiator and
// compares every response against a transaction-level model of the store and statistics.
module tb_imem_read_responder;

    localparam int WORD_AW = 12;
    localparam int LATENCY = 4;
    localparam int CNT_W   = 32;
    localparam int DEPTH   = 1 << WORD_AW;

    logic               cpu_clk;
    logic               rst;
    logic               r_mem;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_r_data;
    logic               mem_ready;
    logic               ld_we;
    logic [WORD_AW-1:0] ld_addr;
    logic [31:0]        ld_data;
    logic               busy;
    logic               proto_err;
    logic [CNT_W-1:0]   refill_cnt;
    logic [CNT_W-1:0]   abort_cnt;

    imem_read_responder #(
        .WORD_AW(WORD_AW),
        .LATENCY(LATENCY),
        .CNT_W  (CNT_W)
    ) dut (
        .cpu_clk   (cpu_clk),
        .rst       (rst),
        .r_mem     (r_mem),
        .mem_addr  (mem_addr),
        .mem_r_data(mem_r_data),
        .mem_ready (mem_ready),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .busy      (busy),
        .proto_err (proto_err),
        .refill_cnt(refill_cnt),
        .abort_cnt (abort_cnt)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    int          nchecks = 0;
    int          nerrors = 0;
    int          cyc = 0;
    logic [31:0] ref_mem [DEPTH];
    int          exp_refill;
    int          exp_abort;
    logic        exp_perr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the rising edge.
    // A preload driven during the cycle lands in the model at the same edge it lands in the DUT.
    task automatic tick();
        @(posedge cpu_clk);
        #1;
        cyc++;
        if (ld_we) begin
            ref_mem[ld_addr] = ld_data;
            ld_we = 1'b0;
        end
    endtask

    function automatic logic [WORD_AW-1:0] idx_of(input logic [31:0] a);
        return WORD_AW'((a / 4) % DEPTH);
    endfunction

    task automatic check_stats(input string tag);
        check({tag, "_refill"}, refill_cnt, exp_refill);
        check({tag, "_abort"}, abort_cnt, exp_abort);
        check({tag, "_perr"}, {31'b0, proto_err}, {31'b0, exp_perr});
    endtask

    task automatic preload(input logic [WORD_AW-1:0] a, input logic [31:0] d);
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
    endtask

    // One complete refill: request from IDLE, optional write-first bypass on the
    // response-entry edge, optional address wobble while waiting.
    task automatic serve(input logic [31:0] addr, input bit byp, input logic [31:0] byp_data,
                         input bit glitch, output int ready_cyc);
        int                 c;
        int                 got;
        logic [WORD_AW-1:0] idx;
        idx = idx_of(addr);
        if ((addr % 4) != 0) exp_perr = 1'b1;
        r_mem    = 1'b1;
        mem_addr = addr;
        c        = 0;
        got      = -1;
        while (got < 0 && c < LATENCY + 3) begin
            if (byp && c == LATENCY - 1) begin
                ld_we   = 1'b1;
                ld_addr = idx;
                ld_data = byp_data;
            end
            if (glitch && c == 1) begin
                mem_addr = addr ^ 32'h0000_0100;
                exp_perr = 1'b1;
            end
            tick();
            c++;
            if (mem_ready === 1'b1) got = c;
        end
        ready_cyc = cyc;
        r_mem     = 1'b0;
        mem_addr  = addr;
        check("latency", got, LATENCY);
        check("rdata", mem_r_data, ref_mem[idx]);
        tick();
        exp_refill++;
        check("ready_pulse", {31'b0, mem_ready}, 32'd0);
        check("busy_after", {31'b0, busy}, 32'd0);
        check_stats("serve");
    endtask

    // Request held for k cycles (1..LATENCY-1) and then withdrawn.
    task automatic abort_req(input logic [31:0] addr, input int k);
        bit seen;
        seen = 1'b0;
        if ((addr % 4) != 0) exp_perr = 1'b1;
        r_mem    = 1'b1;
        mem_addr = addr;
        for (int i = 0; i < k; i++) begin
            tick();
            if (mem_ready === 1'b1) seen = 1'b1;
        end
        check("abort_busy_wait", {31'b0, busy}, 32'd1);
        r_mem = 1'b0;
        tick();
        if (mem_ready === 1'b1) seen = 1'b1;
        exp_abort++;
        check("abort_no_ready", {31'b0, seen}, 32'd0);
        check("abort_busy_low", {31'b0, busy}, 32'd0);
        check_stats("abort");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r1;
        int          r2;
        logic [31:0] a;
        int          op;

        rst        = 1'b1;
        r_mem      = 1'b0;
        mem_addr   = 32'd0;
        ld_we      = 1'b0;
        ld_addr    = '0;
        ld_data    = 32'd0;
        exp_refill = 0;
        exp_abort  = 0;
        exp_perr   = 1'b0;

        repeat (3) @(posedge cpu_clk);
        #3;
        check("rst_ready", {31'b0, mem_ready}, 32'd0);
        check("rst_rdata", mem_r_data, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check_stats("rst");
        rst = 1'b0;
        tick();

        for (int i = 0; i < DEPTH; i++) preload(WORD_AW'(i), $urandom);

        // Single refill from word 5.
        preload(12'd5, 32'hDEAD_BEEF);
        serve(32'h14, 1'b0, 32'd0, 1'b0, r1);
        check("t1_data", mem_r_data, 32'hDEAD_BEEF);

        // Back-to-back refills at the fastest legal rate.
        preload(12'd0, 32'h11);
        preload(12'd1, 32'h22);
        serve(32'h0, 1'b0, 32'd0, 1'b0, r1);
        check("b2b_first", mem_r_data, 32'h11);
        serve(32'h4, 1'b0, 32'd0, 1'b0, r2);
        check("b2b_second", mem_r_data, 32'h22);
        check("b2b_spacing", r2 - r1, LATENCY + 1);

        // Abandoned request, then a normal one.
        abort_req(32'h8, 2);
        serve(32'h8, 1'b0, 32'd0, 1'b0, r1);

        // Write-first bypass on the response-entry edge.
        serve(32'h20, 1'b1, 32'hCAFE_F00D, 1'b0, r1);
        check("bypass_data", mem_r_data, 32'hCAFE_F00D);

        // Unaligned, out-of-range address wraps to word 0 and flags a protocol error.
        serve(32'h4002, 1'b0, 32'd0, 1'b0, r1);
        check("wrap_data", mem_r_data, 32'h11);
        tick();
        check("perr_sticky", {31'b0, proto_err}, 32'd1);

        // Address wobble while waiting: latched address still wins.
        serve(32'h30, 1'b0, 32'd0, 1'b1, r1);

        // Asynchronous reset in the middle of a wait.
        r_mem    = 1'b1;
        mem_addr = 32'h14;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("arst_ready", {31'b0, mem_ready}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_rdata", mem_r_data, 32'd0);
        exp_refill = 0;
        exp_abort  = 0;
        exp_perr   = 1'b0;
        check_stats("arst");
        r_mem = 1'b0;
        #2 rst = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < LATENCY + 2; i++) begin
                tick();
                if (mem_ready === 1'b1) seen = 1'b1;
            end
            check("arst_no_ready", {31'b0, seen}, 32'd0);
        end
        serve(32'h14, 1'b0, 32'd0, 1'b0, r1);
        check("arst_after_data", mem_r_data, 32'hDEAD_BEEF);

        // Randomised traffic.
        for (int n = 0; n < 80; n++) begin
            op = int'($urandom_range(0, 9));
            a  = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            if (op < 2) begin
                abort_req(a, int'($urandom_range(1, LATENCY - 1)));
            end else if (op == 2) begin
                repeat ($urandom_range(1, 3)) preload(WORD_AW'($urandom), $urandom);
            end else begin
                serve(a, ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 5) == 0), r1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
